// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions and sequencer state encoding.
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int unsigned STATUS_IE = 0;
    localparam int unsigned CAUSE_IP  = 10;
    localparam int unsigned EXC_LO    = 2;
    localparam int unsigned EXC_HI    = 6;

    localparam logic [4:0] EXC_INT = 5'd0;

    typedef enum logic {
        StRun,
        StHandler
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous level input; synchronous active-low reset.
module sync_ff #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic clrn,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] ff_q;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[DEPTH-2:0], d};
        end
    end

    assign q = ff_q[DEPTH-1];

endmodule

// File: rtl/intr_pipe_ctrl.sv
// Interrupt sequencer: holds CP0 status/cause/EPC, decides when an interrupt is taken in ID,
// and redirects the PC to the handler vector or back to EPC on eret.
module intr_pipe_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] VECTOR      = 32'h0000_0008,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        intr,
    input  logic        stall,
    input  logic        id_valid,
    input  logic        id_in_slot,
    input  logic        id_eret,
    input  logic [31:0] id_pc,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush_id,
    output logic        flush_if,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        int_ack,
    output logic        in_handler
);

    state_t      state_q, state_d;
    logic        ie_q, ie_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  exc_q, exc_d;
    logic        intr_s;
    logic        take;
    logic        ret;
    logic [31:0] cause;

    logic unused_wdata;
    assign unused_wdata = ^{cp0_wdata[31:7], cp0_wdata[1]};

    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_intr_sync (
        .clk  (clk),
        .clrn (clrn),
        .d    (intr),
        .q    (intr_s)
    );

    // Delay-slot and stalled instructions cannot be killed cleanly; the level request waits.
    assign take = (state_q == StRun) & ie_q & intr_s & id_valid & ~id_in_slot & ~stall;
    assign ret  = (state_q == StHandler) & id_eret & ~stall;

    assign cause = {21'b0, intr_s, 3'b0, exc_q, 2'b0};

    always_comb begin
        flush_id    = take | ret;
        flush_if    = take | ret;
        pc_redirect = take | ret;
        int_ack     = take;
        in_handler  = (state_q == StHandler);
        pc_target   = '0;
        if (take) begin
            pc_target = VECTOR;
        end else if (ret) begin
            pc_target = epc_q;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_STATUS: cp0_rdata[STATUS_IE] = ie_q;
            CP0_CAUSE:  cp0_rdata = cause;
            CP0_EPC:    cp0_rdata = epc_q;
            default:    cp0_rdata = '0;
        endcase
    end

    // mtc0 first, then take/return override so sequencer events win on a shared edge.
    always_comb begin
        state_d = state_q;
        ie_d    = ie_q;
        epc_d   = epc_q;
        exc_d   = exc_q;
        if (cp0_we) begin
            case (cp0_addr)
                CP0_STATUS: ie_d  = cp0_wdata[STATUS_IE];
                CP0_CAUSE:  exc_d = cp0_wdata[EXC_HI:EXC_LO];
                CP0_EPC:    epc_d = cp0_wdata;
                default:    ;
            endcase
        end
        if (take) begin
            epc_d   = id_pc;
            ie_d    = 1'b0;
            exc_d   = EXC_INT;
            state_d = StHandler;
        end
        if (ret) begin
            ie_d    = 1'b1;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= StRun;
            ie_q    <= 1'b0;
            epc_q   <= '0;
            exc_q   <= '0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            epc_q   <= epc_d;
            exc_q   <= exc_d;
        end
    end

endmodule

// File: tb/tb_intr_pipe_ctrl.sv
// Scoreboard bench for intr_pipe_ctrl: directed scenarios followed by random traffic,
// checked against a rule-level reference model.
module tb_intr_pipe_ctrl;

    localparam logic [31:0] VEC = 32'h0000_0008;
    localparam int unsigned SS  = 2;

    logic        clk;
    logic        clrn;
    logic        intr;
    logic        stall;
    logic        id_valid;
    logic        id_in_slot;
    logic        id_eret;
    logic [31:0] id_pc;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        flush_id;
    logic        flush_if;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        int_ack;
    logic        in_handler;

    intr_pipe_ctrl #(
        .VECTOR      (VEC),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .intr        (intr),
        .stall       (stall),
        .id_valid    (id_valid),
        .id_in_slot  (id_in_slot),
        .id_eret     (id_eret),
        .id_pc       (id_pc),
        .cp0_we      (cp0_we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .flush_id    (flush_id),
        .flush_if    (flush_if),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .int_ack     (int_ack),
        .in_handler  (in_handler)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] target;
        bit          ack;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 0;

    // Reference model: the interrupt seen by the core is the input delayed by SS edges.
    bit          m_hnd;
    bit          m_ie;
    logic [31:0] m_epc;
    logic [4:0]  m_exc;
    bit          m_sync[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return {31'b0, m_ie};
            5'd13:   return ({31'b0, m_sync[0]} << 10) | ({27'b0, m_exc} << 2);
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_hnd = 0;
        m_ie  = 0;
        m_epc = 32'h0;
        m_exc = 5'h0;
        m_sync.delete();
        for (int i = 0; i < SS; i++) m_sync.push_back(1'b0);
    endtask

    // One clock: predict this cycle's redirect, then advance the model at the edge.
    task automatic cycle();
        bit take;
        bit ret;
        take = !m_hnd && m_ie && m_sync[0] && id_valid && !id_in_slot && !stall;
        ret  = m_hnd && id_eret && !stall;
        if (take) sbq.push_back('{VEC, 1'b1});
        else if (ret) sbq.push_back('{m_epc, 1'b0});
        @(posedge clk);
        if (!clrn) begin
            m_reset();
        end else begin
            if (cp0_we) begin
                if (cp0_addr == 5'd12) m_ie = cp0_wdata[0];
                if (cp0_addr == 5'd13) m_exc = cp0_wdata[6:2];
                if (cp0_addr == 5'd14) m_epc = cp0_wdata;
            end
            if (take) begin
                m_epc = id_pc;
                m_ie  = 0;
                m_exc = 5'h0;
                m_hnd = 1;
            end
            if (ret) begin
                m_ie  = 1;
                m_hnd = 0;
            end
            m_sync.push_back(intr);
            void'(m_sync.pop_front());
        end
        #1;
    endtask

    task automatic idle_inputs();
        cp0_we     = 0;
        id_eret    = 0;
        stall      = 0;
        id_in_slot = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we    = 1;
        cp0_addr  = a;
        cp0_wdata = d;
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] req);
        cp0_addr = a;
        #1;
        chk(name, cp0_rdata, req);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (pc_redirect) begin
                if (sbq.size() == 0) begin
                    chk("spurious_redirect", {31'b0, pc_redirect}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("redirect_target", pc_target, e.target);
                    chk("int_ack", {31'b0, int_ack}, {31'b0, e.ack});
                    chk("flushes", {30'b0, flush_id, flush_if}, 32'h3);
                end
            end else begin
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("missing_redirect", {31'b0, pc_redirect}, 32'h1);
                end
                chk("idle_strobes", {29'b0, int_ack, flush_id, flush_if}, 32'h0);
                chk("idle_target", pc_target, 32'h0);
            end
            chk("in_handler", {31'b0, in_handler}, {31'b0, m_hnd});
            chk("cp0_rdata", cp0_rdata, m_read(cp0_addr));
        end
    end

    initial begin
        m_reset();
        clrn = 0; intr = 0; id_valid = 0; id_pc = 32'h0;
        cp0_addr = 5'd0; cp0_wdata = 32'h0;
        idle_inputs();
        cycle();
        mon_en = 1;
        cycle();
        clrn = 1;
        read_chk("reset_status", 5'd12, 32'h0);

        // Basic take: request and IE set in cycle 0, take in cycle 2.
        mtc0(5'd12, 32'h1); intr = 1; id_valid = 1; id_pc = 32'h40;
        cycle();
        cp0_we = 0;
        repeat (3) cycle();
        read_chk("basic_epc", 5'd14, 32'h40);
        read_chk("basic_ie", 5'd12, 32'h0);
        chk("basic_in_handler", {31'b0, in_handler}, 32'h1);

        // Reset in the middle of the handler.
        intr = 0; clrn = 0;
        repeat (2) cycle();
        clrn = 1;
        read_chk("rst_status", 5'd12, 32'h0);
        read_chk("rst_epc", 5'd14, 32'h0);
        chk("rst_in_handler", {31'b0, in_handler}, 32'h0);

        // Deferral by delay slot (cycles 2-4) and stall (cycle 5); take in cycle 6.
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (i == 0) begin
                mtc0(5'd12, 32'h1);
                intr = 1;
            end
            id_pc = 32'h200 + 32'(4 * i);
            id_in_slot = (i >= 2 && i <= 4);
            stall = (i == 5);
            cycle();
        end
        idle_inputs();
        read_chk("defer_epc", 5'd14, 32'h218);

        // Return: handler rewrites EPC, eret stalled one cycle, then released.
        intr = 0;
        mtc0(5'd14, 32'h100);
        cycle();
        idle_inputs(); id_eret = 1; stall = 1;
        cycle();
        stall = 0;
        cycle();
        idle_inputs();
        cycle();
        read_chk("ret_status", 5'd12, 32'h1);
        chk("ret_in_handler", {31'b0, in_handler}, 32'h0);

        // eret while running is a nop.
        id_eret = 1;
        repeat (3) cycle();
        id_eret = 0;

        // Masked request: pending with IE=0, taken right after IE is set.
        mtc0(5'd12, 32'h0); intr = 1;
        cycle();
        idle_inputs();
        repeat (20) cycle();
        read_chk("masked_cause", 5'd13, 32'h400);
        mtc0(5'd12, 32'h1);
        cycle();
        idle_inputs();
        cycle();
        chk("masked_taken", {31'b0, in_handler}, 32'h1);

        // Collision: return, then take coinciding with a status write.
        id_eret = 1;
        cycle();
        idle_inputs();
        mtc0(5'd12, 32'h1);
        cycle();
        idle_inputs();
        read_chk("collide_ie", 5'd12, 32'h0);
        chk("collide_in_handler", {31'b0, in_handler}, 32'h1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int unsigned sel;
            clrn       = ($urandom_range(199) != 0);
            if ($urandom_range(15) == 0) intr = ~intr;
            stall      = ($urandom_range(3) == 0);
            id_valid   = ($urandom_range(7) != 0);
            id_in_slot = ($urandom_range(3) == 0);
            id_eret    = ($urandom_range(7) == 0);
            id_pc      = $urandom & 32'hFFFF_FFFC;
            cp0_we     = ($urandom_range(9) == 0);
            sel        = $urandom_range(4);
            cp0_addr   = (sel < 3) ? 5'(12 + sel) : 5'($urandom);
            cp0_wdata  = $urandom;
            cycle();
        end

        clrn = 1; intr = 0;
        idle_inputs();
        repeat (4) cycle();
        chk("drain", sbq.size(), 32'h0);
        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
